// File: rtl/pixel_frame_source.sv
// Streaming frame reader: fetches one greyscale frame in raster order from a
// synchronous-read pixel memory and emits it on a valid/ready stream with
// start-of-frame, end-of-line and end-of-frame markers.
// The memory output register acts as a bypass entry in front of a 2-entry
// FIFO, so the first pixel is presented in the same cycle its read data
// returns and the stream sustains one pixel per clock.
module pixel_frame_source #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                inflight_r;
    logic [DATA_W-1:0]   fifo_mem_r [2];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          count_r;
    logic [XW-1:0]       x_r;
    logic [YW-1:0]       y_r;
    logic                busy_r;
    logic                done_r;

    logic                start_acc_s;
    logic                pop_s;
    logic                push_s;
    logic                deq_s;
    logic [2:0]          level_s;
    logic                rd_en_s;
    logic                last_x_s;
    logic                last_y_s;
    logic                eof_beat_s;
    logic                frame_end_s;

    // Handshake, buffer accounting and read-issue decisions
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && start;
        pix_valid   = (count_r != 2'd0) || inflight_r;
        pop_s       = pix_valid && pix_ready;
        // Returning data bypasses the FIFO when it is empty and taken at once
        push_s      = inflight_r && !((count_r == 2'd0) && pix_ready);
        deq_s       = pop_s && (count_r != 2'd0);
        // Entries held or on their way, with a same-cycle pop freeing one
        level_s     = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_en_s     = (state_r == ST_RUN) && (level_s < 3'd2);
        last_x_s    = (x_r == X_LAST);
        last_y_s    = (y_r == Y_LAST);
        eof_beat_s  = last_x_s && last_y_s;
        frame_end_s = (state_r == ST_FLUSH) && pop_s && eof_beat_s;
    end

    // Output stream view: FIFO head, else the returning read data
    always_comb begin
        pix_data = {DATA_W{1'b0}};
        if (count_r != 2'd0) begin
            pix_data = fifo_mem_r[rd_ptr_r];
        end else if (inflight_r) begin
            pix_data = mem_rd_data;
        end else begin
            pix_data = {DATA_W{1'b0}};
        end
        pix_sof   = pix_valid && (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
        pix_eol   = pix_valid && last_x_s;
        pix_eof   = pix_valid && eof_beat_s;
        mem_rd_en = rd_en_s;
        mem_addr  = rd_addr_r;
        busy      = busy_r;
        done      = done_r;
    end

    // Next-state logic for the frame controller
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (rd_en_s && (rd_addr_r == LAST_ADDR)) next_state_s = ST_FLUSH;
                else                                     next_state_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (pop_s && eof_beat_s) next_state_s = ST_IDLE;
                else                     next_state_s = ST_FLUSH;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Frame controller state register
    always_ff @(posedge clk) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Read counter, in-flight flag, FIFO pointers and output x/y counters
    always_ff @(posedge clk) begin
        if (!rst || start_acc_s) begin
            rd_addr_r  <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
        end else begin
            if (rd_en_s) rd_addr_r <= rd_addr_r + ADDR_W'(1);
            inflight_r <= rd_en_s;
            if (push_s) wr_ptr_r <= ~wr_ptr_r;
            if (deq_s)  rd_ptr_r <= ~rd_ptr_r;
            count_r <= count_r + {1'b0, push_s} - {1'b0, deq_s};
            if (pop_s) begin
                if (last_x_s) begin
                    x_r <= {XW{1'b0}};
                    y_r <= last_y_s ? {YW{1'b0}} : (y_r + YW'(1));
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end
        end
    end

    // FIFO storage written from the memory read port
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_mem_r[0] <= {DATA_W{1'b0}};
            fifo_mem_r[1] <= {DATA_W{1'b0}};
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_rd_data;
        end
    end

    // Busy level and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= frame_end_s;
            if (start_acc_s)      busy_r <= 1'b1;
            else if (frame_end_s) busy_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_frame_source.sv
// Directed self-checking bench for pixel_frame_source (4x3 frame, mem[i]=i+16).
// Expected beats are queued when a frame is started and compared as the DUT
// hands them over; a negedge monitor also checks stall stability, read
// addresses and the buffered-plus-in-flight bound.
module tb_pixel_frame_source;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [11:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;

    logic [7:0]  mem [0:15];
    logic [10:0] sb [$];
    int          tests = 0;
    int          fails = 0;
    int          frame_rd = 0;
    int          frame_hs = 0;
    int          done_cnt = 0;
    int          mode = 0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_beat = 11'd0;

    pixel_frame_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(12), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read pixel memory
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame();
        logic [10:0] e;
        for (int i = 0; i < N; i++) begin
            e = {8'(i + 16), 1'(i == 0), 1'((i % W) == W - 1), 1'(i == N - 1)};
            sb.push_back(e);
        end
        frame_rd = 0;
        frame_hs = 0;
    endtask

    task automatic start_frame(input bit expect_frame);
        start = 1'b1;
        if (expect_frame) push_frame();
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n;
        n = 0;
        while (frame_hs < target && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, 32'(frame_hs), 32'(target));
    endtask

    // pix_ready driver: 0 = held high, 1 = 1,0,0,1,0,1 pattern, 2 = held low
    initial begin
        logic [5:0] pat;
        int pidx;
        pat = 6'b101001;
        pidx = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: pix_ready = 1'b1;
                1: begin
                    pix_ready = pat[pidx];
                    pidx = (pidx + 1) % 6;
                end
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard, stall stability, read addresses, buffer bound, done count
    initial begin
        logic [10:0] beat;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                beat = {pix_data, pix_sof, pix_eol, pix_eof};
                if (mem_rd_en) begin
                    check("rd_addr", 32'(mem_addr), 32'(frame_rd));
                    frame_rd++;
                end
                if (pix_valid && prev_stall) check("stall_stable", 32'(beat), 32'(prev_beat));
                if (pix_valid && pix_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 32'(sb.size() == 0), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("beat", 32'(beat), 32'(e));
                    end
                    frame_hs++;
                end
                check("level_le2", 32'((frame_rd - frame_hs) <= 2), 32'd1);
                prev_stall = pix_valid && !pix_ready;
                prev_beat  = beat;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
        rst   = 1'b0;
        start = 1'b1;

        // Reset with start held high: everything idle
        tick(2);
        check("rst_outs", 32'({busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        tick(1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rd", 32'(mem_rd_en), 32'd0);

        // Full-rate frame
        mode = 0;
        tick(1);
        start_frame(1'b1);
        check("t1_rd_en", 32'(mem_rd_en), 32'd1);
        check("t1_addr", 32'(mem_addr), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_valid", 32'(pix_valid), 32'd0);
        tick(1);
        for (int i = 0; i < N; i++) begin
            check("fr_valid", 32'(pix_valid), 32'd1);
            tick(1);
        end
        check("fr_done", 32'(done), 32'd1);
        check("fr_busy_low", 32'(busy), 32'd0);
        check("fr_valid_low", 32'(pix_valid), 32'd0);
        tick(1);
        check("fr_done_pulse", 32'(done), 32'd0);
        check("fr_done_cnt", 32'(done_cnt), 32'd1);
        check("fr_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure pattern
        mode = 1;
        tick(1);
        start_frame(1'b1);
        wait_done("bp_done");
        tick(1);
        check("bp_hs", 32'(frame_hs), 32'(N));
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'd2);

        // Start while busy is ignored; back-to-back start after done
        mode = 0;
        tick(1);
        d0 = done_cnt;
        start_frame(1'b1);
        wait_hs(5, "sb_wait5");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("sb_done");
        check("sb_hs", 32'(frame_hs), 32'(N));
        check("sb_sb_empty", 32'(sb.size()), 32'd0);
        start_frame(1'b1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b_done");
        tick(1);
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_hs", 32'(frame_hs), 32'(N));
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));

        // Reset after the 7th handshake
        start_frame(1'b1);
        wait_hs(7, "mr_wait7");
        rst = 1'b0;
        d0 = done_cnt;
        tick(1);
        check("mr_valid", 32'(pix_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        sb.delete();
        tick(3);
        check("mr_no_done", 32'(done_cnt), 32'(d0));
        check("mr_valid_idle", 32'(pix_valid), 32'd0);
        start_frame(1'b1);
        wait_done("mr_done");
        tick(1);
        check("mr_hs", 32'(frame_hs), 32'(N));
        check("mr_sb_empty", 32'(sb.size()), 32'd0);

        // Ready held low from start, then released
        mode = 2;
        tick(2);
        start_frame(1'b1);
        tick(10);
        check("rl_reads", 32'(frame_rd), 32'd2);
        check("rl_rd_idle", 32'(mem_rd_en), 32'd0);
        check("rl_valid", 32'(pix_valid), 32'd1);
        check("rl_data", 32'(pix_data), 32'd16);
        check("rl_sof", 32'(pix_sof), 32'd1);
        mode = 0;
        for (int i = 0; i < N; i++) begin
            check("rl_full_rate", 32'(pix_valid), 32'd1);
            tick(1);
        end
        check("rl_done", 32'(done), 32'd1);
        tick(1);
        check("rl_sb_empty", 32'(sb.size()), 32'd0);
        check("rl_hs", 32'(frame_hs), 32'(N));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
